// File: rtl/muldiv_pkg.sv
// Shared definitions for the multiply/divide unit: op encoding, FSM states
// and per-op class masks with small helper functions.
package muldiv_pkg;

   typedef enum logic [2:0] {
      OP_MUL    = 3'b000,
      OP_MULH   = 3'b001,
      OP_MULHSU = 3'b010,
      OP_MULHU  = 3'b011,
      OP_DIV    = 3'b100,
      OP_DIVU   = 3'b101,
      OP_REM    = 3'b110,
      OP_REMU   = 3'b111
   } op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   // Top op bit separates divides from multiplies.
   localparam int OP_DIV_BIT = 2;

   // Bit i set when op i treats that operand as signed. MUL is handled as
   // unsigned because its low product half does not depend on signedness.
   localparam logic [7:0] OPS_SIGNED_A = 8'b0101_0110; // MULH MULHSU DIV REM
   localparam logic [7:0] OPS_SIGNED_B = 8'b0101_0010; // MULH DIV REM
   localparam logic [7:0] OPS_REM      = 8'b1100_0000; // REM REMU

   function automatic logic is_div(input op_e op);
      return op[OP_DIV_BIT];
   endfunction

   function automatic logic signed_a(input op_e op);
      return OPS_SIGNED_A[op];
   endfunction

   function automatic logic signed_b(input op_e op);
      return OPS_SIGNED_B[op];
   endfunction

   function automatic logic is_rem(input op_e op);
      return OPS_REM[op];
   endfunction

endpackage

// File: rtl/muldiv_if.sv
// Request/response handshake bundle between a requester and muldiv_unit.
interface muldiv_if #(
   parameter int XLEN = 32
);
   logic            i_valid;
   logic            o_ready;
   logic [2:0]      i_op;
   logic [XLEN-1:0] i_operand_a;
   logic [XLEN-1:0] i_operand_b;
   logic            i_flush;
   logic            o_valid;
   logic            i_ready;
   logic [XLEN-1:0] o_result;

   // The unit side.
   modport slave (
      input  i_valid, i_op, i_operand_a, i_operand_b, i_flush, i_ready,
      output o_ready, o_valid, o_result
   );

   // The requester side.
   modport master (
      output i_valid, i_op, i_operand_a, i_operand_b, i_flush, i_ready,
      input  o_ready, o_valid, o_result
   );
endinterface

// File: rtl/muldiv_iter.sv
// Iteration engine shared by multiply and divide. Operates on unsigned
// magnitudes only; sign handling lives in the parent.
//   multiply: {hi,lo} starts as {0, multiplier}; each step conditionally adds
//             the multiplicand to hi and shifts the pair right one bit.
//   divide:   {hi,lo} starts as {0, dividend}; each step shifts left into hi
//             and trial-subtracts the divisor (restoring), shifting the
//             quotient bit into lo.
// nxt_hi/nxt_lo expose the step result combinationally so the parent can
// capture the final answer on the same edge as the last step.
module muldiv_iter #(
   parameter int XLEN = 32
) (
   input  logic            i_clk,
   input  logic            i_rst_n,
   input  logic            start,
   input  logic            clear,
   input  logic            en,
   input  logic            div_mode,
   input  logic [XLEN-1:0] a_mag,
   input  logic [XLEN-1:0] b_mag,
   output logic [XLEN-1:0] nxt_hi,
   output logic [XLEN-1:0] nxt_lo,
   output logic            last
);
   localparam int CW = $clog2(XLEN);

   logic [XLEN-1:0] hi, lo, opnd;
   logic [CW-1:0]   cnt;
   logic            mode;
   logic [XLEN:0]   mul_sum, div_shift, div_diff;

   assign last = (cnt == CW'(XLEN - 1));

   // One add/subtract step for the current mode.
   always_comb begin
      mul_sum   = {1'b0, hi} + (lo[0] ? {1'b0, opnd} : '0);
      div_shift = {hi, lo[XLEN-1]};
      div_diff  = div_shift - {1'b0, opnd};
      nxt_hi    = mul_sum[XLEN:1];
      nxt_lo    = {mul_sum[0], lo[XLEN-1:1]};
      if (mode) begin
         // Borrow out (MSB set) means the divisor did not fit: restore.
         if (!div_diff[XLEN]) begin
            nxt_hi = div_diff[XLEN-1:0];
            nxt_lo = {lo[XLEN-2:0], 1'b1};
         end else begin
            nxt_hi = div_shift[XLEN-1:0];
            nxt_lo = {lo[XLEN-2:0], 1'b0};
         end
      end
   end

   // Load on start, step while enabled, wipe on reset or flush.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         hi   <= '0;
         lo   <= '0;
         opnd <= '0;
         cnt  <= '0;
         mode <= 1'b0;
      end else if (clear) begin
         hi   <= '0;
         lo   <= '0;
         opnd <= '0;
         cnt  <= '0;
         mode <= 1'b0;
      end else if (start) begin
         hi   <= '0;
         lo   <= a_mag;
         opnd <= b_mag;
         cnt  <= '0;
         mode <= div_mode;
      end else if (en) begin
         hi   <= nxt_hi;
         lo   <= nxt_lo;
         cnt  <= cnt + 1'b1;
      end
   end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RISC-V style multiply/divide unit with valid/ready handshake.
// Divide-by-zero and signed overflow complete straight from IDLE; all other
// ops spend XLEN cycles in BUSY. Defining MULDIV_FAST_MUL_EN replaces the
// iterative multiply with a single-cycle combinational multiplier.
module muldiv_unit
   import muldiv_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic    i_clk,
   input  logic    i_rst_n,
   muldiv_if.slave bus
);
   localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

   state_e            state, state_nx;
   op_e               op_in, op_q;
   logic              accept, short_path, div_zero, sgn_ovf, fast_mul;
   logic              a_neg, b_neg, q_neg_q, a_neg_q;
   logic [XLEN-1:0]   a_mag, b_mag, short_res, fix_res, result_q;
   logic              iter_start, iter_en, iter_clear, iter_last;
   logic [XLEN-1:0]   nxt_hi, nxt_lo, quo_fix, rem_fix;
   logic [2*XLEN-1:0] prod, prod_fix;

   assign op_in  = op_e'(bus.i_op);
   // Flush wins over a request presented in IDLE.
   assign accept = bus.i_valid & ~bus.i_flush & (state == ST_IDLE);

   // Operand magnitudes and special-case detection on the incoming request.
   always_comb begin
      a_neg    = signed_a(op_in) & bus.i_operand_a[XLEN-1];
      b_neg    = signed_b(op_in) & bus.i_operand_b[XLEN-1];
      a_mag    = a_neg ? -bus.i_operand_a : bus.i_operand_a;
      b_mag    = b_neg ? -bus.i_operand_b : bus.i_operand_b;
      div_zero = is_div(op_in) & (bus.i_operand_b == '0);
      sgn_ovf  = ((op_in == OP_DIV) | (op_in == OP_REM)) &
                 (bus.i_operand_a == MOST_NEG) & (bus.i_operand_b == '1);
   end

`ifdef MULDIV_FAST_MUL_EN
   logic [2*XLEN-1:0] fm_a, fm_b, fm_p;
   assign fm_a     = {{XLEN{signed_a(op_in) & bus.i_operand_a[XLEN-1]}}, bus.i_operand_a};
   assign fm_b     = {{XLEN{signed_b(op_in) & bus.i_operand_b[XLEN-1]}}, bus.i_operand_b};
   assign fm_p     = fm_a * fm_b;
   assign fast_mul = ~is_div(op_in);
`else
   assign fast_mul = 1'b0;
`endif

   assign short_path = div_zero | sgn_ovf | fast_mul;

   // Result for requests that complete without iterating.
   always_comb begin
      short_res = '0;
      if (div_zero) begin
         short_res = is_rem(op_in) ? bus.i_operand_a : '1;
      end else if (sgn_ovf) begin
         short_res = (op_in == OP_DIV) ? bus.i_operand_a : '0;
      end
`ifdef MULDIV_FAST_MUL_EN
      else if (fast_mul) begin
         short_res = (op_in == OP_MUL) ? fm_p[XLEN-1:0] : fm_p[2*XLEN-1:XLEN];
      end
`endif
   end

   // Sign fix-up of the final iteration step, selected by the latched op.
   always_comb begin
      prod     = {nxt_hi, nxt_lo};
      prod_fix = q_neg_q ? -prod : prod;
      quo_fix  = q_neg_q ? -nxt_lo : nxt_lo;
      rem_fix  = a_neg_q ? -nxt_hi : nxt_hi;
      fix_res  = '0;
      case (op_q)
         OP_MUL:                       fix_res = prod_fix[XLEN-1:0];
         OP_MULH, OP_MULHSU, OP_MULHU: fix_res = prod_fix[2*XLEN-1:XLEN];
         OP_DIV, OP_DIVU:              fix_res = quo_fix;
         OP_REM, OP_REMU:              fix_res = rem_fix;
         default:                      fix_res = '0;
      endcase
   end

   muldiv_iter #(.XLEN(XLEN)) u_iter (
      .i_clk    (i_clk),
      .i_rst_n  (i_rst_n),
      .start    (iter_start),
      .clear    (iter_clear),
      .en       (iter_en),
      .div_mode (is_div(op_in)),
      .a_mag    (a_mag),
      .b_mag    (b_mag),
      .nxt_hi   (nxt_hi),
      .nxt_lo   (nxt_lo),
      .last     (iter_last)
   );

   // FSM state register.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) state <= ST_IDLE;
      else          state <= state_nx;
   end

   // FSM next-state logic.
   always_comb begin
      state_nx = state;
      case (state)
         ST_IDLE: if (accept) state_nx = short_path ? ST_DONE : ST_BUSY;
         ST_BUSY: begin
            if (bus.i_flush)    state_nx = ST_IDLE;
            else if (iter_last) state_nx = ST_DONE;
         end
         // Return to IDLE only; a new request waits for the next cycle.
         ST_DONE: if (bus.i_flush | bus.i_ready) state_nx = ST_IDLE;
         default: state_nx = ST_IDLE;
      endcase
   end

   // FSM outputs: handshake flags and iteration engine control.
   always_comb begin
      bus.o_ready = (state == ST_IDLE);
      bus.o_valid = (state == ST_DONE);
      iter_start  = accept & ~short_path;
      iter_en     = (state == ST_BUSY) & ~bus.i_flush;
      iter_clear  = (state == ST_BUSY) & bus.i_flush;
   end

   // Latch op class and sign flags of the accepted request.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         op_q    <= OP_MUL;
         q_neg_q <= 1'b0;
         a_neg_q <= 1'b0;
      end else if (accept) begin
         op_q    <= op_in;
         q_neg_q <= a_neg ^ b_neg;
         a_neg_q <= a_neg;
      end
   end

   // Result register: written on entry to DONE, held until the next one.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         result_q <= '0;
      end else if (accept & short_path) begin
         result_q <= short_res;
      end else if ((state == ST_BUSY) & iter_last & ~bus.i_flush) begin
         result_q <= fix_res;
      end
   end

   assign bus.o_result = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit (XLEN=32): directed corner cases,
// randomized ops against a plain-arithmetic model, back-pressure, flush and
// mid-operation reset. Latency counts the accept edge as edge 1.
module tb_muldiv_unit;
   localparam int XLEN = 32;
   localparam logic [31:0] MIN_NEG = 32'h8000_0000;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   muldiv_if #(.XLEN(XLEN)) bus ();

   muldiv_unit #(.XLEN(XLEN)) dut (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .bus     (bus)
   );

   function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      longint      sa, sb;
      logic [63:0] ua, ub, p;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = {32'b0, a};
      ub = {32'b0, b};
      case (op)
         3'd0: begin p = ua * ub;           return p[31:0];  end
         3'd1: begin p = 64'(sa * sb);      return p[63:32]; end
         3'd2: begin p = 64'(sa * longint'(ub)); return p[63:32]; end
         3'd3: begin p = ua * ub;           return p[63:32]; end
         3'd4: begin
            if (b == 0) return 32'hFFFF_FFFF;
            if (a == MIN_NEG && b == 32'hFFFF_FFFF) return a;
            return 32'(sa / sb);
         end
         3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
         3'd6: begin
            if (b == 0) return a;
            if (a == MIN_NEG && b == 32'hFFFF_FFFF) return 32'h0;
            return 32'(sa % sb);
         end
         default: return (b == 0) ? a : a % b;
      endcase
   endfunction

   function automatic int exp_lat(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      if (op[2] && b == 0) return 1;
      if ((op == 3'd4 || op == 3'd6) && a == MIN_NEG && b == 32'hFFFF_FFFF) return 1;
`ifdef MULDIV_FAST_MUL_EN
      if (!op[2]) return 1;
`endif
      return XLEN + 1;
   endfunction

   function automatic logic [31:0] pick_operand();
      case ($urandom_range(0, 5))
         0: return 32'h0;
         1: return 32'hFFFF_FFFF;
         2: return MIN_NEG;
         3: return 32'h1;
         default: return $urandom;
      endcase
   endfunction

   // Present one request, scramble inputs after the accept edge, and count
   // edges until o_valid (bounded). Returns with o_valid observed, not released.
   task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] res, output int lat);
      @(negedge clk);
      bus.i_valid = 1'b1;
      bus.i_op = op;
      bus.i_operand_a = a;
      bus.i_operand_b = b;
      lat = 0;
      do begin
         @(posedge clk);
         lat++;
         #1;
         if (lat == 1) begin
            bus.i_valid = 1'b0;
            bus.i_op = 3'($urandom);
            bus.i_operand_a = $urandom;
            bus.i_operand_b = $urandom;
         end
      end while (!bus.o_valid && lat < 100);
      res = bus.o_result;
   endtask

   task automatic release_result();
      @(negedge clk);
      bus.i_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.i_ready = 1'b0;
   endtask

   task automatic test_reset();
      bus.i_valid = 1'b0;
      bus.i_op = 3'd0;
      bus.i_operand_a = '0;
      bus.i_operand_b = '0;
      bus.i_flush = 1'b0;
      bus.i_ready = 1'b0;
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      checks++; if (bus.o_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", bus.o_ready); end
      checks++; if (bus.o_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", bus.o_valid); end
      checks++; if (bus.o_result !== 32'h0) begin errors++; $display("FAIL reset_result got=%h exp=0", bus.o_result); end
   endtask

   task automatic test_directed();
      logic [2:0]  ops [11] = '{3'd0, 3'd3, 3'd1, 3'd4, 3'd6, 3'd5, 3'd7, 3'd4, 3'd6, 3'd4, 3'd6};
      logic [31:0] as  [11] = '{32'd7, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFF9, 32'hFFFFFFF9,
                                32'd100, 32'd100, 32'h80000000, 32'h80000000, 32'd5, 32'd5};
      logic [31:0] bs  [11] = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd2, 32'd2,
                                32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 32'd0};
      logic [31:0] exs [11] = '{32'hFFFFFFEB, 32'hFFFFFFFE, 32'h0, 32'hFFFFFFFD, 32'hFFFFFFFF,
                                32'hFFFFFFFF, 32'd100, 32'h80000000, 32'h0, 32'hFFFFFFFF, 32'd5};
      logic [31:0] res;
      int lat;
      for (int i = 0; i < 11; i++) begin
         run_op(ops[i], as[i], bs[i], res, lat);
         checks++;
         if (res !== exs[i]) begin
            errors++;
            $display("FAIL directed_result[%0d] op=%0d got=%h exp=%h", i, ops[i], res, exs[i]);
         end
         checks++;
         if (lat != exp_lat(ops[i], as[i], bs[i])) begin
            errors++;
            $display("FAIL directed_latency[%0d] op=%0d got=%0d exp=%0d", i, ops[i], lat, exp_lat(ops[i], as[i], bs[i]));
         end
         release_result();
      end
   endtask

   task automatic test_random();
      logic [2:0]  op;
      logic [31:0] a, b, res;
      int lat;
      for (int i = 0; i < 60; i++) begin
         op = 3'($urandom_range(0, 7));
         a = pick_operand();
         b = pick_operand();
         run_op(op, a, b, res, lat);
         checks++;
         if (res !== model(op, a, b)) begin
            errors++;
            $display("FAIL random_result op=%0d a=%h b=%h got=%h exp=%h", op, a, b, res, model(op, a, b));
         end
         checks++;
         if (lat != exp_lat(op, a, b)) begin
            errors++;
            $display("FAIL random_latency op=%0d a=%h b=%h got=%0d exp=%0d", op, a, b, lat, exp_lat(op, a, b));
         end
         repeat ($urandom_range(0, 2)) @(posedge clk);
         release_result();
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] a, b, res, res2;
      int lat, n;
      bit stable;
      a = $urandom;
      b = $urandom;
      run_op(3'd2, a, b, res, lat);
      checks++;
      if (res !== model(3'd2, a, b)) begin errors++; $display("FAIL bp_result got=%h exp=%h", res, model(3'd2, a, b)); end
      stable = 1'b1;
      repeat (5) begin
         @(posedge clk);
         #1;
         if (bus.o_valid !== 1'b1 || bus.o_result !== res || bus.o_ready !== 1'b0) stable = 1'b0;
      end
      checks++;
      if (!stable) begin errors++; $display("FAIL bp_hold got=unstable exp=stable valid=%b ready=%b", bus.o_valid, bus.o_ready); end
      // Release with a new request already waiting: it must not be taken yet.
      @(negedge clk);
      bus.i_ready = 1'b1;
      bus.i_valid = 1'b1;
      bus.i_op = 3'd0;
      bus.i_operand_a = 32'd12345;
      bus.i_operand_b = 32'd678;
      @(posedge clk);
      #1;
      bus.i_ready = 1'b0;
      checks++;
      if (bus.o_valid !== 1'b0) begin errors++; $display("FAIL bp_release_valid got=%b exp=0", bus.o_valid); end
      checks++;
      if (bus.o_ready !== 1'b1) begin errors++; $display("FAIL bp_no_same_cycle_accept got=%b exp=1", bus.o_ready); end
      @(posedge clk);
      #1;
      bus.i_valid = 1'b0;
      checks++;
      if (bus.o_ready !== 1'b0) begin errors++; $display("FAIL bp_next_accept got_ready=%b exp=0", bus.o_ready); end
      n = 0;
      while (!bus.o_valid && n < 100) begin @(posedge clk); #1; n++; end
      res2 = bus.o_result;
      checks++;
      if (res2 !== 32'd8369910) begin errors++; $display("FAIL bp_second_result got=%h exp=%h", res2, 32'd8369910); end
      release_result();
   endtask

   task automatic test_flush();
      logic [31:0] res;
      int lat;
      bit seen;
      // Flush a DIV in flight.
      @(negedge clk);
      bus.i_valid = 1'b1;
      bus.i_op = 3'd4;
      bus.i_operand_a = 32'hDEAD_BEEF;
      bus.i_operand_b = 32'd13;
      @(posedge clk);
      #1;
      bus.i_valid = 1'b0;
      repeat (9) @(posedge clk);
      @(negedge clk);
      bus.i_flush = 1'b1;
      @(posedge clk);
      #1;
      bus.i_flush = 1'b0;
      checks++;
      if (bus.o_ready !== 1'b1 || bus.o_valid !== 1'b0) begin
         errors++; $display("FAIL flush_busy ready=%b valid=%b exp ready=1 valid=0", bus.o_ready, bus.o_valid);
      end
      seen = 1'b0;
      repeat (40) begin @(posedge clk); #1; if (bus.o_valid) seen = 1'b1; end
      checks++;
      if (seen) begin errors++; $display("FAIL flush_no_valid got=1 exp=0"); end
      // Flush beats a request in IDLE.
      @(negedge clk);
      bus.i_valid = 1'b1;
      bus.i_flush = 1'b1;
      bus.i_op = 3'd5;
      @(posedge clk);
      #1;
      bus.i_valid = 1'b0;
      bus.i_flush = 1'b0;
      checks++;
      if (bus.o_ready !== 1'b1) begin errors++; $display("FAIL flush_idle_priority got_ready=%b exp=1", bus.o_ready); end
      // Flush a result waiting in DONE.
      run_op(3'd5, 32'd9, 32'd0, res, lat);
      @(negedge clk);
      bus.i_flush = 1'b1;
      @(posedge clk);
      #1;
      bus.i_flush = 1'b0;
      checks++;
      if (bus.o_valid !== 1'b0 || bus.o_ready !== 1'b1) begin
         errors++; $display("FAIL flush_done valid=%b ready=%b exp valid=0 ready=1", bus.o_valid, bus.o_ready);
      end
      // Unit still computes correctly after flushes.
      run_op(3'd6, 32'hFFFF_FF00, 32'd7, res, lat);
      checks++;
      if (res !== model(3'd6, 32'hFFFF_FF00, 32'd7)) begin
         errors++; $display("FAIL flush_recover got=%h exp=%h", res, model(3'd6, 32'hFFFF_FF00, 32'd7));
      end
      release_result();
   endtask

   task automatic test_reset_mid();
      logic [31:0] res;
      int lat;
      @(negedge clk);
      bus.i_valid = 1'b1;
      bus.i_op = 3'd4;
      bus.i_operand_a = 32'd1000;
      bus.i_operand_b = 32'd7;
      @(posedge clk);
      #1;
      bus.i_valid = 1'b0;
      repeat (5) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if (bus.o_result !== 32'h0) begin errors++; $display("FAIL midreset_result got=%h exp=0", bus.o_result); end
      checks++;
      if (bus.o_ready !== 1'b1 || bus.o_valid !== 1'b0) begin
         errors++; $display("FAIL midreset_state ready=%b valid=%b exp ready=1 valid=0", bus.o_ready, bus.o_valid);
      end
      @(negedge clk);
      rst_n = 1'b1;
      run_op(3'd4, 32'd1000, 32'd7, res, lat);
      checks++;
      if (res !== 32'd142) begin errors++; $display("FAIL midreset_recover got=%h exp=%h", res, 32'd142); end
      release_result();
   endtask

   initial begin
      test_reset();
      test_directed();
      test_random();
      test_back_to_back();
      test_flush();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
